// File: rtl/timer_controller.sv
// -----------------------------------------------------------------------------
// timer_controller
//
// Times one of four programmable intervals, counted in whole seconds using an
// external once-per-second tick. The four durations live in a small register
// table that can be rewritten at any time. Rewriting the table does not affect
// an interval that is already counting.
//
// A start request latches the table index and enters LOAD. LOAD pulses
// divider_restart so that the first second is a full second. The selected
// duration is then loaded into remaining. COUNT decrements remaining once per
// tick. DONE pulses expired for one cycle.
//
// Ports
//   clock           system clock; all state updates on its rising edge
//   reset           asynchronous, active-high reset
//   start           one-cycle request to time table[interval_sel]
//   interval_sel    table index, sampled only while start is high
//   reprogram       one-cycle table write strobe
//   time_param_sel  table index written on reprogram
//   time_value      new duration in seconds (0..15)
//   one_hz_enable   one-cycle tick from the seconds divider
//   divider_restart high for the single LOAD cycle; zeroes the divider phase
//   expired         one-cycle pulse when the interval has elapsed
//   busy            high while an interval is loading or counting
//   remaining       seconds left in the current interval
// -----------------------------------------------------------------------------
module timer_controller #(
  parameter logic [3:0] T_ARM_DELAY       = 4'd6,
  parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
  parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] interval_sel,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       one_hz_enable,
  output logic       divider_restart,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] dur_tbl [4];
  logic [1:0] sel_q;
  logic [3:0] load_value;

  assign load_value = dur_tbl[sel_q];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers sample their inputs from the same edge, independent of the
  // order in which the processes are evaluated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A start request wins over every other transition.
  // ---------------------------------------------------------------------------
  // NOTE: the next state gets a default before the case statement. Without
  // that default, any path that left it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        LOAD:    state_next = (load_value != 4'd0) ? COUNT : DONE;
        COUNT:   if (one_hz_enable && remaining == 4'd1) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs, decoded from the state register alone. Because of that,
  // reset clears them as soon as it clears the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    divider_restart = 1'b0;
    expired         = 1'b0;
    busy            = 1'b0;
    case (state)
      LOAD: begin
        divider_restart = 1'b1;
        busy            = 1'b1;
      end
      COUNT:   busy    = 1'b1;
      DONE:    expired = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Duration table. It is writable in any state. A write on the same edge as
  // a start is seen by the following LOAD cycle.
  // ---------------------------------------------------------------------------
  // NOTE: this small table is reset on purpose, because the reset values are
  // the documented default durations. A large storage array would normally be
  // left unreset so that it can map onto RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dur_tbl[0] <= T_ARM_DELAY;
      dur_tbl[1] <= T_DRIVER_DELAY;
      dur_tbl[2] <= T_PASSENGER_DELAY;
      dur_tbl[3] <= T_ALARM_ON;
    end else if (reprogram) begin
      dur_tbl[time_param_sel] <= time_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Interval datapath: latched table index and the seconds-remaining counter.
  // The counter is loaded only when LOAD actually hands over to COUNT or DONE.
  // It moves only on ticks in COUNT, so it holds in IDLE and DONE. It cannot
  // go below zero, because COUNT is never entered with zero remaining.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q     <= 2'd0;
      remaining <= 4'd0;
    end else begin
      if (start) sel_q <= interval_sel;

      if (state == LOAD && !start) begin
        remaining <= load_value;
      end else if (state == COUNT && !start && one_hz_enable
                   && remaining != 4'd0) begin
        remaining <= remaining - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_timer_controller.sv
// -----------------------------------------------------------------------------
// tb_timer_controller
//
// Directed bench for timer_controller. Each step drives one cycle of inputs
// and pushes the expected output vector {divider_restart, expired, busy,
// remaining} for the state after the next clock edge. The vector is popped
// and compared one time unit after that edge. The expected vectors are
// worked out by hand from the intended behaviour. The durations assume the
// default table (6, 8, 15, 10).
// -----------------------------------------------------------------------------
module tb_timer_controller;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] interval_sel;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       divider_restart;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  timer_controller dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .interval_sel   (interval_sel),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .one_hz_enable  (one_hz_enable),
    .divider_restart(divider_restart),
    .expired        (expired),
    .busy           (busy),
    .remaining      (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] ev(input bit dr, input bit ex, input bit bz,
                                    input int rem);
    return {dr, ex, bz, rem[3:0]};
  endfunction

  // Pops the oldest expected vector and compares it with the live outputs.
  task automatic compare_one();
    sb_t        e;
    logic [6:0] obs;
    obs = {divider_restart, expired, busy, remaining};
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard: observed empty queue, required a pending vector");
    end else begin
      e = sb_q.pop_front();
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed dr=%b ex=%b busy=%b rem=%0d, required dr=%b ex=%b busy=%b rem=%0d",
               e.tag, obs[6], obs[5], obs[4], obs[3:0],
               e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
      end
    end
  endtask

  // One clock cycle: drive the inputs, record the expected post-edge outputs,
  // then clock and compare.
  task automatic cyc(input string tag, input logic st, input logic [1:0] sel,
                     input logic rp, input logic [1:0] psel,
                     input logic [3:0] val, input logic tk,
                     input logic [6:0] exp);
    start          = st;
    interval_sel   = sel;
    reprogram      = rp;
    time_param_sel = psel;
    time_value     = val;
    one_hz_enable  = tk;
    sb_q.push_back('{tag, exp});
    @(posedge clock);
    #1;
    compare_one();
  endtask

  task automatic idle(input string tag, input logic [6:0] exp);
    cyc(tag, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, exp);
  endtask

  task automatic tick(input string tag, input logic [6:0] exp);
    cyc(tag, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1, exp);
  endtask

  task automatic go(input string tag, input logic [1:0] sel,
                    input logic [6:0] exp);
    cyc(tag, 1'b1, sel, 1'b0, 2'd0, 4'd0, 1'b0, exp);
  endtask

  task automatic prog(input string tag, input logic [1:0] psel,
                      input logic [3:0] val, input logic [6:0] exp);
    cyc(tag, 1'b0, 2'd0, 1'b1, psel, val, 1'b0, exp);
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    interval_sel   = 2'd0;
    reprogram      = 1'b0;
    time_param_sel = 2'd0;
    time_value     = 4'd0;
    one_hz_enable  = 1'b0;

    // Reset state
    #1;
    sb_q.push_back('{"reset_state", ev(0, 0, 0, 0)});
    compare_one();
    #5 reset = 1'b0;               // one time unit after a rising edge

    // Default entry 0 (6 s), full count to expiry
    go  ("t1_load",     2'd0, ev(1, 0, 1, 0));
    idle("t1_count6",         ev(0, 0, 1, 6));
    tick("t1_tick5",          ev(0, 0, 1, 5));
    tick("t1_tick4",          ev(0, 0, 1, 4));
    tick("t1_tick3",          ev(0, 0, 1, 3));
    idle("t1_hold3",          ev(0, 0, 1, 3));
    tick("t1_tick2",          ev(0, 0, 1, 2));
    tick("t1_tick1",          ev(0, 0, 1, 1));
    tick("t1_done",           ev(0, 1, 0, 0));
    idle("t1_idle",           ev(0, 0, 0, 0));
    tick("t1_idle_tick",      ev(0, 0, 0, 0));

    // Reprogram entry 2 to 3 s; a tick during LOAD must be ignored
    prog("t2_prog",     2'd2, 4'd3, ev(0, 0, 0, 0));
    go  ("t2_load",     2'd2, ev(1, 0, 1, 0));
    tick("t2_load_tick",      ev(0, 0, 1, 3));
    tick("t2_tick2",          ev(0, 0, 1, 2));
    tick("t2_tick1",          ev(0, 0, 1, 1));
    tick("t2_done",           ev(0, 1, 0, 0));
    tick("t2_done_tick",      ev(0, 0, 0, 0));

    // Zero-length interval: LOAD straight to DONE
    prog("t3_prog",     2'd1, 4'd0, ev(0, 0, 0, 0));
    go  ("t3_load",     2'd1, ev(1, 0, 1, 0));
    idle("t3_done",           ev(0, 1, 0, 0));
    idle("t3_idle",           ev(0, 0, 0, 0));

    // Restart during COUNT abandons the interval without expired
    go  ("t4_load3",    2'd3, ev(1, 0, 1, 0));
    idle("t4_count10",        ev(0, 0, 1, 10));
    tick("t4_tick9",          ev(0, 0, 1, 9));
    tick("t4_tick8",          ev(0, 0, 1, 8));
    tick("t4_tick7",          ev(0, 0, 1, 7));
    tick("t4_tick6",          ev(0, 0, 1, 6));
    go  ("t4_restart",  2'd0, ev(1, 0, 1, 6));
    idle("t4_count6",         ev(0, 0, 1, 6));

    // Start plus same-entry reprogram; a later reprogram leaves the count alone
    cyc ("t5_start_prog", 1'b1, 2'd0, 1'b1, 2'd0, 4'd2, 1'b0, ev(1, 0, 1, 6));
    idle("t5_count2",         ev(0, 0, 1, 2));
    prog("t5_prog_mid", 2'd0, 4'd9, ev(0, 0, 1, 2));
    tick("t5_tick1",          ev(0, 0, 1, 1));
    tick("t5_done",           ev(0, 1, 0, 0));
    idle("t5_idle",           ev(0, 0, 0, 0));
    go  ("t5_load9",    2'd0, ev(1, 0, 1, 0));
    idle("t5_count9",         ev(0, 0, 1, 9));

    // Reset in the middle of COUNT with 5 s remaining
    tick("t6_tick8",          ev(0, 0, 1, 8));
    tick("t6_tick7",          ev(0, 0, 1, 7));
    tick("t6_tick6",          ev(0, 0, 1, 6));
    tick("t6_tick5",          ev(0, 0, 1, 5));
    #3 reset = 1'b1;               // well away from any clock edge
    #1;
    sb_q.push_back('{"t6_async_reset", ev(0, 0, 0, 0)});
    compare_one();
    @(posedge clock);
    #1;
    sb_q.push_back('{"t6_reset_held", ev(0, 0, 0, 0)});
    compare_one();
    reset = 1'b0;
    tick("t6_no_expired",     ev(0, 0, 0, 0));

    // Table restored to its defaults
    go  ("t6_load0",    2'd0, ev(1, 0, 1, 0));
    idle("t6_def0",           ev(0, 0, 1, 6));
    go  ("t6_load1",    2'd1, ev(1, 0, 1, 6));
    idle("t6_def1",           ev(0, 0, 1, 8));
    go  ("t6_load2",    2'd2, ev(1, 0, 1, 8));
    idle("t6_def2",           ev(0, 0, 1, 15));
    go  ("t6_load3",    2'd3, ev(1, 0, 1, 15));
    idle("t6_def3",           ev(0, 0, 1, 10));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
